// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer and a saturating starved-cycle counter.
module pipe_stage_reg #(
    parameter int          WIDTH     = 32,
    parameter int          SKID      = 1,
    parameter logic [31:0] NOP_VALUE = 32'h0000_0013,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] bubble_cnt
);

    localparam logic [WIDTH-1:0] NOP_W = WIDTH'(NOP_VALUE);

    logic             main_valid_r;
    logic [WIDTH-1:0] main_r;
    logic             skid_valid_r;
    logic [WIDTH-1:0] skid_r;
    logic [CNT_W-1:0] cnt_r;
    logic             accept_s;
    logic             emit_s;

    generate
        if (SKID != 0) begin : g_skid_ready
            assign in_ready = ~skid_valid_r;
        end else begin : g_comb_ready
            assign in_ready = ~main_valid_r | out_ready;
        end
    endgenerate

    assign accept_s   = in_valid & in_ready;
    assign emit_s     = main_valid_r & out_ready;
    assign out_valid  = main_valid_r;
    // main_r is forced to the NOP pattern whenever empty, so out_data is a plain flop.
    assign out_data   = main_r;
    assign bubble_cnt = cnt_r;

    // Main/skid entry update: refill main from skid first, then from the input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid_r <= 1'b0;
            main_r       <= NOP_W;
            skid_valid_r <= 1'b0;
            skid_r       <= {WIDTH{1'b0}};
        end else if (flush) begin
            main_valid_r <= 1'b0;
            main_r       <= NOP_W;
            skid_valid_r <= 1'b0;
        end else if (emit_s || !main_valid_r) begin
            if (skid_valid_r) begin
                main_r       <= skid_r;
                main_valid_r <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (accept_s) begin
                main_r       <= in_data;
                main_valid_r <= 1'b1;
            end else begin
                main_r       <= NOP_W;
                main_valid_r <= 1'b0;
            end
        end else if (accept_s && (SKID != 0)) begin
            skid_r       <= in_data;
            skid_valid_r <= 1'b1;
        end
    end

    // Starved-cycle counter: empty while downstream is ready, saturating, reset-only clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!flush && !main_valid_r && out_ready && (cnt_r != {CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: instance 0 is SKID=1/CNT_W=4, instance 1 is SKID=0/CNT_W=16,
// both checked against a queue-based transaction model.
module tb_pipe_stage_reg;

    logic        clk;
    logic        reset;
    logic        flush     [2];
    logic        in_valid  [2];
    logic        out_ready [2];
    logic [31:0] in_data   [2];
    logic        in_ready  [2];
    logic        out_valid [2];
    logic [31:0] out_data  [2];
    logic [3:0]  bc0;
    logic [15:0] bc1;
    logic [15:0] bcnt      [2];

    assign bcnt[0] = {12'h000, bc0};
    assign bcnt[1] = bc1;

    pipe_stage_reg #(.WIDTH(32), .SKID(1), .NOP_VALUE(32'h0000_0013), .CNT_W(4)) u_skid (
        .clk(clk), .reset(reset), .flush(flush[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .bubble_cnt(bc0));

    pipe_stage_reg #(.WIDTH(32), .SKID(0), .NOP_VALUE(32'h0000_0013), .CNT_W(16)) u_comb (
        .clk(clk), .reset(reset), .flush(flush[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .bubble_cnt(bc1));

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Transaction model: queue of words held by the stage, plus bubble count.
    logic [31:0] q [2][$];
    int          mcnt [2];
    int          cmax [2] = '{15, 65535};
    logic        ev [2];
    logic        er [2];
    logic [31:0] ed [2];
    logic [15:0] ec [2];

    task automatic compute_exp();
        for (int i = 0; i < 2; i++) begin
            ev[i] = (q[i].size() > 0);
            ed[i] = ev[i] ? q[i][0] : 32'h0000_0013;
            er[i] = (i == 0) ? (q[i].size() < 2) : ((q[i].size() == 0) || out_ready[i]);
            ec[i] = mcnt[i][15:0];
        end
    endtask

    task automatic advance();
        for (int i = 0; i < 2; i++) begin
            logic acc, em;
            acc = in_valid[i] & er[i];
            em  = ev[i] & out_ready[i];
            if (!ev[i] && out_ready[i] && !flush[i] && mcnt[i] < cmax[i]) mcnt[i]++;
            if (em) void'(q[i].pop_front());
            if (flush[i]) q[i].delete();
            else if (acc) q[i].push_back(in_data[i]);
        end
        @(negedge clk);
    endtask

    task automatic drive(int i, logic v, logic [31:0] d, logic r, logic f);
        in_valid[i] = v; in_data[i] = d; out_ready[i] = r; flush[i] = f;
        #1;
        compute_exp();
    endtask

    task automatic idle(int i);
        in_valid[i] = 1'b0; out_ready[i] = 1'b0; flush[i] = 1'b0; in_data[i] = 32'h0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            q[i].delete();
            mcnt[i] = 0;
        end
    endtask

    task automatic test_reset();
        drive(0, 1'b1, 32'h0000_0050, 1'b0, 1'b0); advance();
        drive(0, 1'b1, 32'h0000_0054, 1'b0, 1'b0); advance();
        drive(1, 1'b1, 32'h0000_0060, 1'b0, 1'b0); advance();
        reset = 1'b0;
        clear_model();
        for (int k = 0; k < 2; k++) begin
            #1;
            for (int i = 0; i < 2; i++) begin
                tests++;
                if ({out_valid[i], in_ready[i], bcnt[i], out_data[i]} !== {1'b0, 1'b1, 16'h0000, 32'h0000_0013}) begin
                    fails++;
                    $display("FAIL reset inst%0d: got v=%b r=%b cnt=%0d d=%h want v=0 r=1 cnt=0 d=00000013",
                             i, out_valid[i], in_ready[i], bcnt[i], out_data[i]);
                end
            end
            @(negedge clk);
        end
        idle(0); idle(1);
        reset = 1'b1;
    endtask

    task automatic test_pass_through();
        logic [31:0] words [3] = '{32'h100, 32'h104, 32'h108};
        for (int k = 0; k < 6; k++) begin
            if (k < 3) drive(0, 1'b1, words[k], 1'b1, 1'b0);
            else       drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
            tests++;
            if ({out_valid[0], in_ready[0], bcnt[0], out_data[0]} !== {ev[0], er[0], ec[0], ed[0]}) begin
                fails++;
                $display("FAIL pass_through cyc%0d: got v=%b r=%b cnt=%0d d=%h want v=%b r=%b cnt=%0d d=%h",
                         k, out_valid[0], in_ready[0], bcnt[0], out_data[0], ev[0], er[0], ec[0], ed[0]);
            end
            if (k >= 1 && k <= 3) begin
                tests++;
                if (out_valid[0] !== 1'b1 || out_data[0] !== words[k-1]) begin
                    fails++;
                    $display("FAIL pass_latency cyc%0d: got v=%b d=%h want v=1 d=%h", k, out_valid[0], out_data[0], words[k-1]);
                end
            end
            advance();
        end
        idle(0);
    endtask

    task automatic test_stall_skid();
        for (int k = 0; k < 9; k++) begin
            case (k)
                0:       drive(0, 1'b1, 32'h0000_000A, 1'b0, 1'b0);
                1:       drive(0, 1'b1, 32'h0000_000B, 1'b0, 1'b0);
                2, 3, 4: drive(0, 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
                default: drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
            endcase
            tests++;
            if ({out_valid[0], in_ready[0], bcnt[0], out_data[0]} !== {ev[0], er[0], ec[0], ed[0]}) begin
                fails++;
                $display("FAIL stall_skid cyc%0d: got v=%b r=%b cnt=%0d d=%h want v=%b r=%b cnt=%0d d=%h",
                         k, out_valid[0], in_ready[0], bcnt[0], out_data[0], ev[0], er[0], ec[0], ed[0]);
            end
            advance();
        end
        idle(0);
    endtask

    task automatic test_flush();
        for (int k = 0; k < 7; k++) begin
            case (k)
                0:       drive(0, 1'b1, 32'h0000_000C, 1'b0, 1'b0);
                1:       drive(0, 1'b1, 32'h0000_000D, 1'b0, 1'b0);
                2:       drive(0, 1'b1, 32'h0000_000E, 1'b0, 1'b1);
                default: drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
            endcase
            tests++;
            if ({out_valid[0], in_ready[0], bcnt[0], out_data[0]} !== {ev[0], er[0], ec[0], ed[0]}) begin
                fails++;
                $display("FAIL flush cyc%0d: got v=%b r=%b cnt=%0d d=%h want v=%b r=%b cnt=%0d d=%h",
                         k, out_valid[0], in_ready[0], bcnt[0], out_data[0], ev[0], er[0], ec[0], ed[0]);
            end
            if (k >= 3) begin
                tests++;
                if (out_valid[0] !== 1'b0 || out_data[0] !== 32'h0000_0013) begin
                    fails++;
                    $display("FAIL flush_bubble cyc%0d: got v=%b d=%h want v=0 d=00000013", k, out_valid[0], out_data[0]);
                end
            end
            advance();
        end
        idle(0);
    endtask

    task automatic test_bubble_sat();
        reset = 1'b0;
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 26; k++) begin
            if (k < 20)      drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
            else if (k < 22) drive(0, 1'b1, 32'h0000_0777 + k, 1'b0, 1'b0);
            else             drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
            tests++;
            if ({out_valid[0], in_ready[0], bcnt[0], out_data[0]} !== {ev[0], er[0], ec[0], ed[0]}) begin
                fails++;
                $display("FAIL bubble_sat cyc%0d: got v=%b r=%b cnt=%0d d=%h want v=%b r=%b cnt=%0d d=%h",
                         k, out_valid[0], in_ready[0], bcnt[0], out_data[0], ev[0], er[0], ec[0], ed[0]);
            end
            if (k >= 16) begin
                tests++;
                if (bcnt[0] !== 16'd15) begin
                    fails++;
                    $display("FAIL bubble_saturated cyc%0d: got cnt=%0d want cnt=15", k, bcnt[0]);
                end
            end
            advance();
        end
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0); advance();
        drive(0, 1'b0, 32'h0, 1'b1, 1'b0); advance();
        idle(0);
    endtask

    task automatic test_comb_ready();
        int sent = 0;
        for (int k = 0; k < 400; k++) begin
            logic r;
            r = (k < 8) ? logic'(k[0]) : logic'($urandom_range(1));
            if (sent < 64) drive(1, 1'b1, 32'hC000_0000 + sent, r, 1'b0);
            else           drive(1, 1'b0, 32'h0, 1'b1, 1'b0);
            tests++;
            if ({out_valid[1], in_ready[1], bcnt[1], out_data[1]} !== {ev[1], er[1], ec[1], ed[1]}) begin
                fails++;
                $display("FAIL comb_ready cyc%0d: got v=%b r=%b cnt=%0d d=%h want v=%b r=%b cnt=%0d d=%h",
                         k, out_valid[1], in_ready[1], bcnt[1], out_data[1], ev[1], er[1], ec[1], ed[1]);
            end
            if (k >= 1 && k < 8) begin
                tests++;
                if (in_ready[1] !== out_ready[1]) begin
                    fails++;
                    $display("FAIL comb_track cyc%0d: got in_ready=%b want %b", k, in_ready[1], out_ready[1]);
                end
            end
            if (in_valid[1] && er[1]) sent++;
            advance();
        end
        tests++;
        if (q[1].size() != 0 || out_valid[1] !== 1'b0) begin
            fails++;
            $display("FAIL comb_drain: got v=%b model_left=%0d want v=0 model_left=0", out_valid[1], q[1].size());
        end
        idle(1);
    endtask

    task automatic test_soak(int i);
        for (int k = 0; k < 10000; k++) begin
            drive(i, logic'($urandom_range(1)), $urandom, logic'($urandom_range(1)),
                  logic'($urandom_range(99) < 5));
            tests++;
            if ({out_valid[i], in_ready[i], bcnt[i], out_data[i]} !== {ev[i], er[i], ec[i], ed[i]}) begin
                fails++;
                $display("FAIL soak inst%0d cyc%0d: got v=%b r=%b cnt=%0d d=%h want v=%b r=%b cnt=%0d d=%h",
                         i, k, out_valid[i], in_ready[i], bcnt[i], out_data[i], ev[i], er[i], ec[i], ed[i]);
            end
            advance();
        end
        idle(i);
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b0;
        idle(0); idle(1);
        clear_model();
        compute_exp();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_pass_through();
        test_stall_skid();
        test_flush();
        test_bubble_sat();
        test_comb_ready();
        test_soak(0);
        test_soak(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
